// File: rtl/msrv_32_integer_file.sv
// msrv_32_integer_file
// Architectural integer register file for the MSRV32 core with a per-register
// busy scoreboard for hazard detection.
//
// Ports:
//   clk_in, rst_n_in            core clock, async active-low reset
//   rs1_addr_in / rs1_out       read port 1 (combinational)
//   rs2_addr_in / rs2_out       read port 2 (combinational)
//   rd_addr_in, wr_en_in, rd_in write-back commit port
//   flush_in                    kills the write and clears the scoreboard
//   issue_en_in, issue_rd_in    marks an issuing instruction's destination busy
//   rs1_busy_out, rs2_busy_out  outstanding-write flags for the read addresses
//
// Optional feature macro: MSRV32_RF_BYPASS_EN
//   defined   -> a write committing this cycle is forwarded to matching read
//                ports and their busy flags read 0
//   undefined -> reads return the stored array and stored scoreboard only

module msrv_32_integer_file #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic [4:0]      rs1_addr_in,
  input  logic [4:0]      rs2_addr_in,
  output logic [XLEN-1:0] rs1_out,
  output logic [XLEN-1:0] rs2_out,
  input  logic [4:0]      rd_addr_in,
  input  logic            wr_en_in,
  input  logic [XLEN-1:0] rd_in,
  input  logic            flush_in,
  input  logic            issue_en_in,
  input  logic [4:0]      issue_rd_in,
  output logic            rs1_busy_out,
  output logic            rs2_busy_out
);

  localparam int unsigned NREG = 32;

  // Entry 0 is never written, so it stays at its reset value of 0 and is
  // pruned in synthesis; reads of x0 are also masked explicitly below.
  logic [XLEN-1:0] regs_q [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;

  logic            wr_commit_c;
  logic [XLEN-1:0] rs1_stored_c;
  logic [XLEN-1:0] rs2_stored_c;

  // A write commits only when requested, not flushed, and not aimed at x0.
  assign wr_commit_c = wr_en_in & ~flush_in & (rd_addr_in != 5'd0);

  // Register array update.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < int'(NREG); i++) begin
        regs_q[i] <= '0;
      end
    end else if (wr_commit_c) begin
      regs_q[rd_addr_in] <= rd_in;
    end
  end

  // Scoreboard next state: commit clears first, then issue sets so the
  // younger issue wins; flush overrides both.
  always_comb begin
    busy_d = busy_q;
    if (flush_in) begin
      busy_d = '0;
    end else begin
      if (wr_commit_c) begin
        busy_d[rd_addr_in] = 1'b0;
      end
      if (issue_en_in && (issue_rd_in != 5'd0)) begin
        busy_d[issue_rd_in] = 1'b1;
      end
    end
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Stored-value reads with x0 hardwired to zero.
  assign rs1_stored_c = (rs1_addr_in == 5'd0) ? '0 : regs_q[rs1_addr_in];
  assign rs2_stored_c = (rs2_addr_in == 5'd0) ? '0 : regs_q[rs2_addr_in];

`ifdef MSRV32_RF_BYPASS_EN
  logic rs1_hit_c;
  logic rs2_hit_c;

  // Same-cycle commit to the read address forwards the write data.
  assign rs1_hit_c    = wr_commit_c & (rd_addr_in == rs1_addr_in);
  assign rs2_hit_c    = wr_commit_c & (rd_addr_in == rs2_addr_in);

  assign rs1_out      = rs1_hit_c ? rd_in : rs1_stored_c;
  assign rs2_out      = rs2_hit_c ? rd_in : rs2_stored_c;
  assign rs1_busy_out = busy_q[rs1_addr_in] & ~rs1_hit_c;
  assign rs2_busy_out = busy_q[rs2_addr_in] & ~rs2_hit_c;
`else
  assign rs1_out      = rs1_stored_c;
  assign rs2_out      = rs2_stored_c;
  assign rs1_busy_out = busy_q[rs1_addr_in];
  assign rs2_busy_out = busy_q[rs2_addr_in];
`endif

endmodule

// File: tb/tb_msrv_32_integer_file.sv
// Testbench for msrv_32_integer_file: post-reset sweep, a table of directed
// per-cycle vectors, then same-cycle write/read and mid-cycle reset sequences.

module tb_msrv_32_integer_file;

  logic        clk_in;
  logic        rst_n_in;
  logic [4:0]  rs1_addr_in;
  logic [4:0]  rs2_addr_in;
  logic [31:0] rs1_out;
  logic [31:0] rs2_out;
  logic [4:0]  rd_addr_in;
  logic        wr_en_in;
  logic [31:0] rd_in;
  logic        flush_in;
  logic        issue_en_in;
  logic [4:0]  issue_rd_in;
  logic        rs1_busy_out;
  logic        rs2_busy_out;

  int n_vec;
  int n_err;

  msrv_32_integer_file #(.XLEN(32)) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .rs1_addr_in  (rs1_addr_in),
    .rs2_addr_in  (rs2_addr_in),
    .rs1_out      (rs1_out),
    .rs2_out      (rs2_out),
    .rd_addr_in   (rd_addr_in),
    .wr_en_in     (wr_en_in),
    .rd_in        (rd_in),
    .flush_in     (flush_in),
    .issue_en_in  (issue_en_in),
    .issue_rd_in  (issue_rd_in),
    .rs1_busy_out (rs1_busy_out),
    .rs2_busy_out (rs2_busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        wr;
    logic [31:0] wd;
    logic        fl;
    logic        iss;
    logic [4:0]  ird;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        b1;
    logic        b2;
  } vec_t;

  localparam int NV = 18;
  vec_t vecs [NV];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2,
                              input logic [4:0] rd, input logic wr,
                              input logic [31:0] wd, input logic fl,
                              input logic iss, input logic [4:0] ird,
                              input logic [31:0] e1, input logic [31:0] e2,
                              input logic b1, input logic b2);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.rd = rd; v.wr = wr; v.wd = wd; v.fl = fl;
    v.iss = iss; v.ird = ird; v.e1 = e1; v.e2 = e2; v.b1 = b1; v.b2 = b2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    wr_en_in = 1'b0; rd_addr_in = 5'd0; rd_in = '0;
    flush_in = 1'b0; issue_en_in = 1'b0; issue_rd_in = 5'd0;
  endtask

  task automatic apply(input vec_t v, input int idx);
    @(posedge clk_in);
    #1;
    rs1_addr_in = v.rs1; rs2_addr_in = v.rs2;
    rd_addr_in = v.rd; wr_en_in = v.wr; rd_in = v.wd;
    flush_in = v.fl; issue_en_in = v.iss; issue_rd_in = v.ird;
    @(negedge clk_in);
    chk($sformatf("v%0d rs1_out", idx), rs1_out, v.e1);
    chk($sformatf("v%0d rs2_out", idx), rs2_out, v.e2);
    chk($sformatf("v%0d rs1_busy", idx), 32'(rs1_busy_out), 32'(v.b1));
    chk($sformatf("v%0d rs2_busy", idx), 32'(rs2_busy_out), 32'(v.b2));
  endtask

  logic [31:0] exp_d;
  logic        exp_b;

  initial begin
    n_vec = 0;
    n_err = 0;

    //          rs1 rs2 rd  wr wd            fl iss ird  e1            e2            b1 b2
    vecs[0]  = mk(0, 31, 0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(1, 2,  5, 1, 32'h12345678, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    vecs[2]  = mk(5, 0,  0, 0, 32'h0,        0, 0, 0,  32'h12345678, 32'h0,        0, 0);
    vecs[3]  = mk(3, 4,  0, 1, 32'hDEADBEEF, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    vecs[4]  = mk(0, 0,  0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0);
    vecs[5]  = mk(5, 7,  0, 0, 32'h0,        0, 1, 7,  32'h12345678, 32'h0,        0, 0);
    vecs[6]  = mk(5, 7,  0, 0, 32'h0,        0, 0, 0,  32'h12345678, 32'h0,        0, 1);
    vecs[7]  = mk(5, 8,  7, 1, 32'hFEEDFACE, 0, 0, 0,  32'h12345678, 32'h0,        0, 0);
    vecs[8]  = mk(7, 7,  0, 0, 32'h0,        0, 0, 0,  32'hFEEDFACE, 32'hFEEDFACE, 0, 0);
    vecs[9]  = mk(5, 6,  7, 1, 32'h11112222, 0, 1, 7,  32'h12345678, 32'h0,        0, 0);
    vecs[10] = mk(7, 7,  0, 0, 32'h0,        0, 0, 0,  32'h11112222, 32'h11112222, 1, 1);
    vecs[11] = mk(3, 9,  0, 0, 32'h0,        0, 1, 3,  32'h0,        32'h0,        0, 0);
    vecs[12] = mk(3, 9,  0, 0, 32'h0,        0, 1, 9,  32'h0,        32'h0,        1, 0);
    vecs[13] = mk(3, 7,  9, 1, 32'hAAAA5555, 1, 1, 10, 32'h0,        32'h11112222, 1, 1);
    vecs[14] = mk(9, 3,  0, 0, 32'h0,        0, 0, 0,  32'h0,        32'h0,        0, 0);
    vecs[15] = mk(7, 10, 0, 0, 32'h0,        0, 0, 0,  32'h11112222, 32'h0,        0, 0);
    vecs[16] = mk(1, 2, 31, 1, 32'h80000001, 0, 0, 0,  32'h0,        32'h0,        0, 0);
    vecs[17] = mk(31, 5, 0, 0, 32'h0,        0, 0, 0,  32'h80000001, 32'h12345678, 0, 0);

    // Reset with immediate zero outputs.
    rst_n_in = 1'b0;
    rs1_addr_in = 5'd0; rs2_addr_in = 5'd0;
    drive_idle();
    repeat (2) @(negedge clk_in);
    for (int a = 0; a < 32; a++) begin
      rs1_addr_in = 5'(a);
      rs2_addr_in = 5'(31 - a);
      #1;
      chk($sformatf("reset rs1 x%0d", a), rs1_out, 32'h0);
      chk($sformatf("reset rs2 x%0d", 31 - a), rs2_out, 32'h0);
      chk($sformatf("reset busy1 x%0d", a), 32'(rs1_busy_out), 32'h0);
      chk($sformatf("reset busy2 x%0d", 31 - a), 32'(rs2_busy_out), 32'h0);
    end
    @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int i = 0; i < NV; i++) begin
      apply(vecs[i], i);
    end

    // Same-cycle write/read of x12 with x12 busy.
    @(posedge clk_in); #1;
    rs1_addr_in = 5'd5; rs2_addr_in = 5'd6;
    rd_addr_in = 5'd12; wr_en_in = 1'b1; rd_in = 32'h01020304;
    flush_in = 1'b0; issue_en_in = 1'b1; issue_rd_in = 5'd12;
    @(posedge clk_in); #1;
    rs1_addr_in = 5'd12;
    rd_addr_in = 5'd12; wr_en_in = 1'b1; rd_in = 32'hBABECAFE;
    issue_en_in = 1'b0;
`ifdef MSRV32_RF_BYPASS_EN
    exp_d = 32'hBABECAFE; exp_b = 1'b0;
`else
    exp_d = 32'h01020304; exp_b = 1'b1;
`endif
    @(negedge clk_in);
    chk("bypass rs1_out", rs1_out, exp_d);
    chk("bypass rs1_busy", 32'(rs1_busy_out), 32'(exp_b));
    @(posedge clk_in); #1;
    drive_idle();
    @(negedge clk_in);
    chk("after write x12", rs1_out, 32'hBABECAFE);
    chk("after write x12 busy", 32'(rs1_busy_out), 32'h0);

    // Reset asserted mid-cycle with a pending write and issue.
    @(posedge clk_in); #1;
    rs1_addr_in = 5'd5; rs2_addr_in = 5'd14;
    rd_addr_in = 5'd13; wr_en_in = 1'b1; rd_in = 32'h00005A5A;
    issue_en_in = 1'b1; issue_rd_in = 5'd14;
    #1;
    rst_n_in = 1'b0;
    #1;
    chk("midreset x5", rs1_out, 32'h0);
    chk("midreset busy2", 32'(rs2_busy_out), 32'h0);
    @(negedge clk_in);
    drive_idle();
    rst_n_in = 1'b1;
    @(posedge clk_in); #1;
    rs1_addr_in = 5'd13; rs2_addr_in = 5'd14;
    #1;
    chk("midreset x13 lost", rs1_out, 32'h0);
    chk("midreset x14 busy", 32'(rs2_busy_out), 32'h0);
    rs1_addr_in = 5'd12; rs2_addr_in = 5'd7;
    #1;
    chk("midreset x12 cleared", rs1_out, 32'h0);
    chk("midreset x7 cleared", rs2_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/msrv_32_integer_file.md
# msrv_32_integer_file

Architectural integer register file for the MSRV32 core, directly downstream of `msrv_32_wb_mux_sel_unit`: it commits `wb_mux_out` into the destination register at the end of the write-back stage. It provides two asynchronous read ports for the decode/operand stage. A per-register busy scoreboard lets the hazard logic stall consumers of results still in flight.

## Interface
- `XLEN`, 32: data width of every register and data port.
- `clk_in`  in  1  core clock; all state updates on the rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `rs1_addr_in`  in  5  read port 1 address.
- `rs2_addr_in`  in  5  read port 2 address.
- `rs1_out`  out  XLEN  read port 1 data.
- `rs2_out`  out  XLEN  read port 2 data.
- `rd_addr_in`  in  5  write-back destination register.
- `wr_en_in`  in  1  write-back commit request, from the stage-3 pipeline register.
- `rd_in`  in  XLEN  write-back data, driven by `wb_mux_out`.
- `flush_in`  in  1  pipeline flush: kills the write and clears the scoreboard.
- `issue_en_in`  in  1  decode issues an instruction that will write `issue_rd_in`.
- `issue_rd_in`  in  5  destination of the issuing instruction.
- `rs1_busy_out`  out  1  `rs1_addr_in` has an outstanding write.
- `rs2_busy_out`  out  1  `rs2_addr_in` has an outstanding write.

## Operation
- Storage: x1..x31, XLEN bits each. x0 is not stored; any read of address 0 returns 0.
- Write: on a rising edge where `wr_en_in`=1, `flush_in`=0 and `rd_addr_in`≠0, the register at `rd_addr_in` takes `rd_in`.
  - A write to x0 is silently dropped.
- Reads are combinational from the stored array, subject to the bypass described under Configuration.
- Scoreboard: `busy[31:1]`, with `busy[0]` tied to 0.
  - On a rising edge, `busy[issue_rd_in]` is set when `issue_en_in`=1 and `issue_rd_in`≠0.
  - On a rising edge, `busy[rd_addr_in]` is cleared when a write commits.
  - If the same register is set and cleared on the same edge, the set wins, because the new issue is younger.
  - `flush_in`=1 clears all busy bits on that edge and overrides any issue.
- `rsN_busy_out` = `busy[rsN_addr_in]`, combinational.
  - When bypass is compiled in, the output is forced to 0 if a write to that address commits in the current cycle.

## Timing
- Reset (async assert, sync release): all registers become 0 and all busy bits become 0. Consequently `rs1_out`=`rs2_out`=0 and both busy outputs are 0 immediately on assertion.
- Write latency: the data is architecturally visible from the cycle after the commit edge. It is visible in the same cycle when bypass is compiled in.
- Read latency: 0 cycles (combinational).
- Reset asserted mid-cycle: any pending write that cycle is lost and the state is cleared.
- `flush_in` and `wr_en_in` asserted together: the write is suppressed, because flush has priority.

## Configuration
- `MSRV32_RF_BYPASS_EN` defined: write-through forwarding is enabled.
  - If the same-cycle write commits (`wr_en_in`=1, `flush_in`=0, `rd_addr_in`≠0, `rd_addr_in`=`rsN_addr_in`), then `rsN_out`=`rd_in`.
  - In that case the matching busy output reads 0.
- Not defined: reads always return the stored value. A same-cycle write becomes visible only after the edge, and the busy output reflects the stored scoreboard state.

## Test plan
- Reset, then read x0..x31 -> every read returns 0 and both busy outputs are 0.
- Write x5=0x12345678 with `wr_en_in`=1, then on the next cycle read `rs1_addr_in`=5 -> `rs1_out`=0x12345678.
- Write x0=0xDEADBEEF, then read x0 on both ports -> both return 0; `rs2_busy_out`=0.
- Issue rd=7, then read rs2=7 -> `rs2_busy_out`=1. Commit the write of x7=0xFEEDFACE -> busy clears on the following cycle and `rs2_out`=0xFEEDFACE. On an edge where x7 is both issued and committed -> busy stays 1.
- Assert `flush_in` together with a write to x9 and outstanding busy bits on x3/x9 -> x9 is unchanged and all busy bits are 0 after the edge.
- Bypass: write x12=0xBABECAFE while reading rs1=12 in the same cycle -> `rs1_out`=0xBABECAFE in that cycle with the macro defined, or the old x12 value without it.
